cc_regwrite_arbiter: RTL and testbench

CC_REGWRITE_ARBITER -- requirements
Module: cc_regwrite_arbiter

---
 rtl/cc_regwrite_arbiter.sv | 136 +++++++++++++
 tb/tb_cc_regwrite_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cc_regwrite_arbiter.sv
// cc_regwrite_arbiter: round-robin arbiter that lets one of three requesters
// (ALU writeback, PC update, IR load) write one register per cycle, using
// active-low write strobes. All outputs are registered, with a latency of 1.
// Optional feature: define CC_REGWRITE_ARBITER_G0_PROTECT_EN to suppress
// writes to g0 (select 0). A suppressed write is still granted, but it drives
// no strobe and pulses the error output instead.
module cc_regwrite_arbiter #(
  parameter int DATAWIDTH_BUS               = 32,
  parameter int DATAWIDTH_DECODER_SELECTION = 4,
  parameter int DATAWIDTH_DECODER_OUT       = 16
) (
  input  logic                                   CC_REGWRITE_ARBITER_CLOCK_50,
  input  logic                                   CC_REGWRITE_ARBITER_RESET_InHigh,
  input  logic [2:0]                             CC_REGWRITE_ARBITER_Req_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_REGWRITE_ARBITER_Sel0_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_REGWRITE_ARBITER_Sel1_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] CC_REGWRITE_ARBITER_Sel2_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]               CC_REGWRITE_ARBITER_Data0_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]               CC_REGWRITE_ARBITER_Data1_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]               CC_REGWRITE_ARBITER_Data2_InBUS,
  output logic [2:0]                             CC_REGWRITE_ARBITER_Grant_OutBUS,
  output logic [DATAWIDTH_DECODER_OUT-1:0]       CC_REGWRITE_ARBITER_Write_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]               CC_REGWRITE_ARBITER_Data_OutBUS,
  output logic                                   CC_REGWRITE_ARBITER_Err_Out
);

  // Highest implemented register: IR at select 13. Selects above it do not exist.
  localparam logic [DATAWIDTH_DECODER_SELECTION-1:0] SEL_MAX =
    DATAWIDTH_DECODER_SELECTION'(13);

  logic                                   clk;
  logic                                   rst;
  logic [2:0]                             req_p0;
  logic [2:0]                             pick_p0;
  logic                                   vld_p0;
  logic [1:0]                             idx_p0;
  logic [2:0]                             oh_p0;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] sel_p0;
  logic [DATAWIDTH_BUS-1:0]               data_p0;
  logic [2:0]                             grant_p1;
  logic [DATAWIDTH_DECODER_OUT-1:0]       write_n_p1;
  logic [DATAWIDTH_BUS-1:0]               data_p1;
  logic                                   err_p1;
  logic [1:0]                             last_q;

  assign clk = CC_REGWRITE_ARBITER_CLOCK_50;
  assign rst = CC_REGWRITE_ARBITER_RESET_InHigh;

  // Round-robin search that starts just after the last granted index.
  // The result is {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    logic [1:0] win;
    idx   = (last == 2'd2) ? 2'd0 : last + 2'd1;
    found = 1'b0;
    win   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return {found, win};
  endfunction

  // A select is suppressed when it names no register, or when it names the
  // protected g0.
  function automatic logic sel_suppressed(input logic [DATAWIDTH_DECODER_SELECTION-1:0] sel);
`ifdef CC_REGWRITE_ARBITER_G0_PROTECT_EN
    return (sel > SEL_MAX) || (sel == '0);
`else
    return (sel > SEL_MAX);
`endif
  endfunction

  // Active-low one-cold strobe; a suppressed select leaves all strobes high.
  function automatic logic [DATAWIDTH_DECODER_OUT-1:0] strobe_decode(
    input logic [DATAWIDTH_DECODER_SELECTION-1:0] sel);
    logic [DATAWIDTH_DECODER_OUT-1:0] s;
    s = '1;
    if (!sel_suppressed(sel)) s[sel] = 1'b0;
    return s;
  endfunction

  // ---- stage p0: mask the current grant holder, pick a winner, mux its select/data
  // Pick and mux the winning requester for this edge.
  always_comb begin
    req_p0  = CC_REGWRITE_ARBITER_Req_InBUS & ~grant_p1;
    pick_p0 = rr_pick(req_p0, last_q);
    vld_p0  = pick_p0[2];
    idx_p0  = pick_p0[1:0];
    oh_p0   = vld_p0 ? 3'(3'b001 << idx_p0) : 3'b000;
    sel_p0  = CC_REGWRITE_ARBITER_Sel0_InBUS;
    data_p0 = CC_REGWRITE_ARBITER_Data0_InBUS;
    case (idx_p0)
      2'd1: begin
        sel_p0  = CC_REGWRITE_ARBITER_Sel1_InBUS;
        data_p0 = CC_REGWRITE_ARBITER_Data1_InBUS;
      end
      2'd2: begin
        sel_p0  = CC_REGWRITE_ARBITER_Sel2_InBUS;
        data_p0 = CC_REGWRITE_ARBITER_Data2_InBUS;
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered grant/strobe/data/err; the pointer advances on every grant
  // Register the outputs and the round-robin pointer. Reset clears the data
  // as well, so that the reset state of every output is defined.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_p1   <= 3'b000;
      write_n_p1 <= '1;
      data_p1    <= '0;
      err_p1     <= 1'b0;
      last_q     <= 2'd2;
    end else begin
      grant_p1   <= oh_p0;
      write_n_p1 <= vld_p0 ? strobe_decode(sel_p0) : '1;
      err_p1     <= vld_p0 && sel_suppressed(sel_p0);
      if (vld_p0) begin
        data_p1 <= data_p0;
        last_q  <= idx_p0;
      end
    end
  end

  assign CC_REGWRITE_ARBITER_Grant_OutBUS = grant_p1;
  assign CC_REGWRITE_ARBITER_Write_OutBUS = write_n_p1;
  assign CC_REGWRITE_ARBITER_Data_OutBUS  = data_p1;
  assign CC_REGWRITE_ARBITER_Err_Out      = err_p1;

endmodule

// File: tb/tb_cc_regwrite_arbiter.sv
// Directed testbench for cc_regwrite_arbiter. The expected values are worked
// out by hand from the register map and the round-robin rules.
module tb_cc_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [3:0]  sel0, sel1, sel2;
  logic [31:0] d0, d1, d2;
  logic [2:0]  grant;
  logic [15:0] wr_n;
  logic [31:0] dout;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cc_regwrite_arbiter dut (
    .CC_REGWRITE_ARBITER_CLOCK_50    (clk),
    .CC_REGWRITE_ARBITER_RESET_InHigh(rst),
    .CC_REGWRITE_ARBITER_Req_InBUS   (req),
    .CC_REGWRITE_ARBITER_Sel0_InBUS  (sel0),
    .CC_REGWRITE_ARBITER_Sel1_InBUS  (sel1),
    .CC_REGWRITE_ARBITER_Sel2_InBUS  (sel2),
    .CC_REGWRITE_ARBITER_Data0_InBUS (d0),
    .CC_REGWRITE_ARBITER_Data1_InBUS (d1),
    .CC_REGWRITE_ARBITER_Data2_InBUS (d2),
    .CC_REGWRITE_ARBITER_Grant_OutBUS(grant),
    .CC_REGWRITE_ARBITER_Write_OutBUS(wr_n),
    .CC_REGWRITE_ARBITER_Data_OutBUS (dout),
    .CC_REGWRITE_ARBITER_Err_Out     (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle, so that outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic [15:0] w,
                            input logic e);
    chk({tag, ".grant"}, 64'(grant), 64'(g));
    chk({tag, ".wr_n"},  64'(wr_n),  64'(w));
    chk({tag, ".err"},   64'(err),   64'(e));
  endtask

  logic [15:0] g0_wr_exp;
  logic        g0_err_exp;

  initial begin
`ifdef CC_REGWRITE_ARBITER_G0_PROTECT_EN
    g0_wr_exp  = 16'hFFFF;
    g0_err_exp = 1'b1;
`else
    g0_wr_exp  = 16'hFFFE;
    g0_err_exp = 1'b0;
`endif
    rst = 1'b1; req = 3'b111;
    sel0 = 4'd3; sel1 = 4'd8; sel2 = 4'd13;
    d0 = 32'h11; d1 = 32'h22; d2 = 32'h33;

    // Hold reset for two cycles with every request high.
    tick(); expect_out("rst1", 3'b000, 16'hFFFF, 1'b0); chk("rst1.data", 64'(dout), 64'h0);
    tick(); expect_out("rst2", 3'b000, 16'hFFFF, 1'b0); chk("rst2.data", 64'(dout), 64'h0);

    // Release reset: requesters are served round-robin, starting with requester 0.
    rst = 1'b0;
    tick(); expect_out("rr0", 3'b001, 16'hFFF7, 1'b0); chk("rr0.data", 64'(dout), 64'h11);
    tick(); expect_out("rr1", 3'b010, 16'hFEFF, 1'b0); chk("rr1.data", 64'(dout), 64'h22);
    tick(); expect_out("rr2", 3'b100, 16'hDFFF, 1'b0); chk("rr2.data", 64'(dout), 64'h33);
    tick(); expect_out("rr3", 3'b001, 16'hFFF7, 1'b0);
    req = 3'b000;
    tick(); expect_out("idle", 3'b000, 16'hFFFF, 1'b0);

    // With only requester 0 active, it is granted on alternate cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b001; sel0 = 4'd5; d0 = 32'hA5A5A5A5;
    tick(); expect_out("solo0", 3'b001, 16'hFFDF, 1'b0); chk("solo0.data", 64'(dout), 64'hA5A5A5A5);
    tick(); expect_out("solo1", 3'b000, 16'hFFFF, 1'b0);
    tick(); expect_out("solo2", 3'b001, 16'hFFDF, 1'b0);
    tick(); expect_out("solo3", 3'b000, 16'hFFFF, 1'b0);
    req = 3'b000; tick();

    // Select 14 names no register: it is granted, no strobe fires, and err pulses once.
    req = 3'b010; sel1 = 4'd14;
    tick(); expect_out("sel14", 3'b010, 16'hFFFF, 1'b1);
    req = 3'b000;
    tick(); expect_out("sel14.after", 3'b000, 16'hFFFF, 1'b0);

    // Select 15 behaves the same way.
    req = 3'b100; sel2 = 4'd15;
    tick(); expect_out("sel15", 3'b100, 16'hFFFF, 1'b1);
    req = 3'b000; tick();

    // Select 0 (g0) depends on whether the protection build option is enabled.
    req = 3'b001; sel0 = 4'd0;
    tick(); expect_out("g0", 3'b001, g0_wr_exp, g0_err_exp);
    req = 3'b000; tick();

    // After requester 1 is granted, the search starts at requester 2.
    sel0 = 4'd3; sel1 = 4'd8; sel2 = 4'd13;
    req = 3'b010; tick(); expect_out("ptr.g1", 3'b010, 16'hFEFF, 1'b0);
    req = 3'b101; tick(); expect_out("ptr.g2", 3'b100, 16'hDFFF, 1'b0);
    req = 3'b000; tick();

    // A request pulse that falls between edges has no effect.
    req = 3'b001; #2; req = 3'b000;
    tick(); expect_out("glitch", 3'b000, 16'hFFFF, 1'b0);

    // Reset in the sampling cycle discards the grant and restores requester 0 priority.
    req = 3'b010; tick(); expect_out("pre.rst", 3'b010, 16'hFEFF, 1'b0);
    req = 3'b111; rst = 1'b1;
    tick(); expect_out("midrst", 3'b000, 16'hFFFF, 1'b0);
    rst = 1'b0;
    tick(); expect_out("postrst", 3'b001, 16'hFFF7, 1'b0);
    req = 3'b000; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
